// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with a per-register pending-writer
// scoreboard.
//
// Two write ports (w1 = ALU result, w2 = load result), three combinational
// read ports (A, B, shift), and a busy bit per register.  A busy bit is set
// when an instruction issues (bsy_set_*) and cleared when a write lands.
// busy_count is a registered population count of the busy bits.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   w1_en/w1_addr/w1_data          write port 1 (wins over w2 on same address)
//   w2_en/w2_addr/w2_data          write port 2
//   A_addr/B_addr/shift_addr       read addresses
//   A_data/B_data/shift_data       read data (0 for addresses >= NREGS)
//   A_busy/B_busy/shift_busy       pending-writer flag of the addressed register
//   bsy_set_en/bsy_set_addr        mark a register pending
//   busy_count                     number of pending registers
module regfile_mp #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 16,
  parameter  int BYPASS = 1,
  localparam int ADDR_W = $clog2(NREGS),
  localparam int CNT_W  = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              w2_en,
  input  logic [ADDR_W-1:0] w2_addr,
  input  logic [DATA_W-1:0] w2_data,
  input  logic [ADDR_W-1:0] A_addr,
  input  logic [ADDR_W-1:0] B_addr,
  input  logic [ADDR_W-1:0] shift_addr,
  output logic [DATA_W-1:0] A_data,
  output logic [DATA_W-1:0] B_data,
  output logic [DATA_W-1:0] shift_data,
  output logic              A_busy,
  output logic              B_busy,
  output logic              shift_busy,
  input  logic              bsy_set_en,
  input  logic [ADDR_W-1:0] bsy_set_addr,
  output logic [CNT_W-1:0]  busy_count
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic w1_ok;
  logic w2_ok;
  logic w2_keep;
  logic set_ok;

  // Addresses need not cover a power of two; anything at or above NREGS
  // is treated as a non-existent register.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  assign w1_ok   = w1_en && in_range(w1_addr);
  assign w2_ok   = w2_en && in_range(w2_addr);
  // w1 takes the register when both ports target it.
  assign w2_keep = w2_ok && !(w1_ok && (w1_addr == w2_addr));
  assign set_ok  = bsy_set_en && in_range(bsy_set_addr);

  function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
    return (BYPASS != 0) && ((w1_ok && (w1_addr == a)) || (w2_ok && (w2_addr == a)));
  endfunction

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if ((BYPASS != 0) && w1_ok && (w1_addr == a)) begin
      d = w1_data;
    end else if ((BYPASS != 0) && w2_ok && (w2_addr == a)) begin
      d = w2_data;
    end else if (in_range(a)) begin
      d = regs[a];
    end
    return d;
  endfunction

  // A forwarded read already carries the result its consumer was waiting
  // for, so it is reported as not pending.
  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    if (in_range(a) && !fwd_hit(a)) begin
      b = busy[a];
    end
    return b;
  endfunction

  always_comb begin
    A_data     = rd_data(A_addr);
    B_data     = rd_data(B_addr);
    shift_data = rd_data(shift_addr);
    A_busy     = rd_busy(A_addr);
    B_busy     = rd_busy(B_addr);
    shift_busy = rd_busy(shift_addr);
  end

  // Next busy vector: writes clear, issue sets; set is applied last so it
  // wins on the same register.  The count is taken from the next vector so
  // the registered count tracks the registered bits exactly.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if ((w1_ok && (w1_addr == ADDR_W'(i))) || (w2_ok && (w2_addr == ADDR_W'(i)))) begin
        busy_nxt[i] = 1'b0;
      end
      if (set_ok && (bsy_set_addr == ADDR_W'(i))) begin
        busy_nxt[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (w2_keep) begin
        regs[w2_addr] <= w2_data;
      end
      if (w1_ok) begin
        regs[w1_addr] <= w1_data;
      end
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        w1_en, w2_en, bsy_set_en;
  logic [3:0]  w1_addr, w2_addr, bsy_set_addr;
  logic [31:0] w1_data, w2_data;
  logic [3:0]  a_addr, b_addr, s_addr;

  logic [31:0] a_data [3];
  logic [31:0] b_data [3];
  logic [31:0] s_data [3];
  logic        a_busy [3];
  logic        b_busy [3];
  logic        s_busy [3];
  logic [4:0]  cnt0, cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // Instance 0: NREGS=16 with forwarding, 1: NREGS=16 without, 2: NREGS=12.
  regfile_mp #(.DATA_W(32), .NREGS(16), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .w2_en(w2_en), .w2_addr(w2_addr), .w2_data(w2_data),
    .A_addr(a_addr), .B_addr(b_addr), .shift_addr(s_addr),
    .A_data(a_data[0]), .B_data(b_data[0]), .shift_data(s_data[0]),
    .A_busy(a_busy[0]), .B_busy(b_busy[0]), .shift_busy(s_busy[0]),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr),
    .busy_count(cnt0)
  );

  regfile_mp #(.DATA_W(32), .NREGS(16), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .w2_en(w2_en), .w2_addr(w2_addr), .w2_data(w2_data),
    .A_addr(a_addr), .B_addr(b_addr), .shift_addr(s_addr),
    .A_data(a_data[1]), .B_data(b_data[1]), .shift_data(s_data[1]),
    .A_busy(a_busy[1]), .B_busy(b_busy[1]), .shift_busy(s_busy[1]),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr),
    .busy_count(cnt1)
  );

  regfile_mp #(.DATA_W(32), .NREGS(12), .BYPASS(1)) u_small (
    .clk(clk), .rst_n(rst_n),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .w2_en(w2_en), .w2_addr(w2_addr), .w2_data(w2_data),
    .A_addr(a_addr), .B_addr(b_addr), .shift_addr(s_addr),
    .A_data(a_data[2]), .B_data(b_data[2]), .shift_data(s_data[2]),
    .A_busy(a_busy[2]), .B_busy(b_busy[2]), .shift_busy(s_busy[2]),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr),
    .busy_count(cnt2)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_reg  [3][16];
  bit          m_busy [3][16];

  function automatic int nr(int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic bit byp(int k);
    return k != 1;
  endfunction

  function automatic int get_cnt(int k);
    if (k == 0) return int'(cnt0);
    if (k == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        for (int r = 0; r < 16; r++) begin
          m_reg[k][r]  = '0;
          m_busy[k][r] = 1'b0;
        end
      end else begin
        // w2 first so that w1 overwrites it on a shared address
        if (w2_en && int'(w2_addr) < nr(k)) m_reg[k][w2_addr] = w2_data;
        if (w1_en && int'(w1_addr) < nr(k)) m_reg[k][w1_addr] = w1_data;
        if (w2_en && int'(w2_addr) < nr(k)) m_busy[k][w2_addr] = 1'b0;
        if (w1_en && int'(w1_addr) < nr(k)) m_busy[k][w1_addr] = 1'b0;
        if (bsy_set_en && int'(bsy_set_addr) < nr(k)) m_busy[k][bsy_set_addr] = 1'b1;
      end
    end
  endtask

  function automatic bit fwd(int k, logic [3:0] a);
    if (!byp(k) || int'(a) >= nr(k)) return 1'b0;
    return (w1_en && w1_addr == a) || (w2_en && w2_addr == a);
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [3:0] a);
    if (int'(a) >= nr(k)) return '0;
    if (byp(k) && w1_en && w1_addr == a) return w1_data;
    if (byp(k) && w2_en && w2_addr == a) return w2_data;
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [3:0] a);
    if (int'(a) >= nr(k) || fwd(k, a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic int exp_cnt(int k);
    int n = 0;
    for (int r = 0; r < 16; r++) n += int'(m_busy[k][r]);
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1;
    w1_en = 1'b0; w1_addr = '0; w1_data = '0;
    w2_en = 1'b0; w2_addr = '0; w2_data = '0;
    bsy_set_en = 1'b0; bsy_set_addr = '0;
    a_addr = '0; b_addr = '0; s_addr = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    w1_en = 1'b1; w1_addr = 4'd1; w1_data = 32'h55;
    bsy_set_en = 1'b1; bsy_set_addr = 4'd1;
    tick();
    tick();
    idle();
    a_addr = 4'd0; b_addr = 4'd1; s_addr = 4'd15;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_data[k] !== 32'h0 || b_data[k] !== 32'h0 || s_data[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data k=%0d got %h/%h/%h exp 0", k, a_data[k], b_data[k], s_data[k]);
      end
      checks++;
      if (a_busy[k] !== 1'b0 || b_busy[k] !== 1'b0 || s_busy[k] !== 1'b0 || get_cnt(k) != 0) begin
        errors++;
        $display("FAIL reset_busy k=%0d got %b%b%b cnt %0d exp 000 cnt 0",
                 k, a_busy[k], b_busy[k], s_busy[k], get_cnt(k));
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      idle();
      w1_en = 1'b1; w1_addr = 4'(i); w1_data = 32'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 14; i++) begin
      a_addr = 4'(i); b_addr = 4'(i + 1); s_addr = 4'(i + 2);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic [31:0] ea, eb, es;
        ea = (k == 2) ? exp_data(2, a_addr) : 32'(i);
        eb = (k == 2) ? exp_data(2, b_addr) : 32'(i + 1);
        es = (k == 2) ? exp_data(2, s_addr) : 32'(i + 2);
        checks++;
        if (a_data[k] !== ea || b_data[k] !== eb || s_data[k] !== es) begin
          errors++;
          $display("FAIL fill i=%0d k=%0d got %h/%h/%h exp %h/%h/%h",
                   i, k, a_data[k], b_data[k], s_data[k], ea, eb, es);
        end
      end
    end
  endtask

  task automatic test_dual_write();
    idle();
    w1_en = 1'b1; w1_addr = 4'd3; w1_data = 32'hAAAA5555;
    w2_en = 1'b1; w2_addr = 4'd3; w2_data = 32'h12345678;
    tick();
    w1_addr = 4'd4; w1_data = 32'd7;
    w2_addr = 4'd5; w2_data = 32'd9;
    tick();
    idle();
    a_addr = 4'd3; b_addr = 4'd4; s_addr = 4'd5;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_data[k] !== 32'hAAAA5555 || b_data[k] !== 32'd7 || s_data[k] !== 32'd9) begin
        errors++;
        $display("FAIL dual_write k=%0d got %h/%h/%h exp aaaa5555/7/9",
                 k, a_data[k], b_data[k], s_data[k]);
      end
    end
  endtask

  task automatic test_bypass();
    tick();
    idle();
    a_addr = 4'd6; w2_en = 1'b1; w2_addr = 4'd6; w2_data = 32'hDEADBEEF;
    b_addr = 4'd9; w1_en = 1'b1; w1_addr = 4'd9; w1_data = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (a_data[0] !== 32'hDEADBEEF || b_data[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_fwd got %h/%h exp deadbeef/cafef00d", a_data[0], b_data[0]);
    end
    checks++;
    if (a_data[1] !== 32'd6 || b_data[1] !== 32'd9) begin
      errors++;
      $display("FAIL nobypass_old got %h/%h exp 6/9", a_data[1], b_data[1]);
    end
    tick();
    idle();
    a_addr = 4'd6;
    @(negedge clk);
    checks++;
    if (a_data[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL nobypass_after got %h exp deadbeef", a_data[1]);
    end
    tick();
    w1_en = 1'b1; w1_addr = 4'd10; w1_data = 32'h1111;
    w2_en = 1'b1; w2_addr = 4'd10; w2_data = 32'h2222;
    a_addr = 4'd10;
    @(negedge clk);
    checks++;
    if (a_data[0] !== 32'h1111 || a_data[1] !== 32'd10) begin
      errors++;
      $display("FAIL bypass_prio got %h/%h exp 1111/a", a_data[0], a_data[1]);
    end
    tick();
    idle();
    a_addr = 4'd10;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_data[k] !== 32'h1111) begin
        errors++;
        $display("FAIL write_prio k=%0d got %h exp 1111", k, a_data[k]);
      end
    end
  endtask

  task automatic test_busy();
    tick();
    idle();
    bsy_set_en = 1'b1; bsy_set_addr = 4'd2;
    tick();
    idle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_cnt(k) != 1) begin
        errors++;
        $display("FAIL busy_cnt1 k=%0d got %0d exp 1", k, get_cnt(k));
      end
    end
    tick();
    bsy_set_en = 1'b1; bsy_set_addr = 4'd7;
    tick();
    idle();
    a_addr = 4'd2;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_cnt(k) != 2 || a_busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL busy_cnt2 k=%0d got cnt %0d busy %b exp 2 1", k, get_cnt(k), a_busy[k]);
      end
    end
    tick();
    w1_en = 1'b1; w1_addr = 4'd2; w1_data = 32'h22;
    tick();
    idle();
    a_addr = 4'd2;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_cnt(k) != 1 || a_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL busy_clear k=%0d got cnt %0d busy %b exp 1 0", k, get_cnt(k), a_busy[k]);
      end
    end
    tick();
    bsy_set_en = 1'b1; bsy_set_addr = 4'd7;
    w1_en = 1'b1; w1_addr = 4'd7; w1_data = 32'h77;
    a_addr = 4'd7;
    @(negedge clk);
    checks++;
    if (a_busy[0] !== 1'b0 || a_busy[1] !== 1'b1 || a_data[0] !== 32'h77) begin
      errors++;
      $display("FAIL busy_fwd got %b/%b data %h exp 0/1 77", a_busy[0], a_busy[1], a_data[0]);
    end
    tick();
    idle();
    a_addr = 4'd7;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_cnt(k) != 1 || a_busy[k] !== 1'b1 || a_data[k] !== 32'h77) begin
        errors++;
        $display("FAIL set_wins k=%0d got cnt %0d busy %b data %h exp 1 1 77",
                 k, get_cnt(k), a_busy[k], a_data[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    tick();
    idle();
    w1_en = 1'b1; w1_addr = 4'd13; w1_data = 32'hFF;
    bsy_set_en = 1'b1; bsy_set_addr = 4'd13;
    a_addr = 4'd13;
    @(negedge clk);
    checks++;
    if (a_data[2] !== 32'h0 || a_busy[2] !== 1'b0 || a_data[0] !== 32'hFF) begin
      errors++;
      $display("FAIL oor_fwd got %h busy %b big %h exp 0 0 ff", a_data[2], a_busy[2], a_data[0]);
    end
    tick();
    idle();
    a_addr = 4'd13; b_addr = 4'd12; s_addr = 4'd15;
    @(negedge clk);
    checks++;
    if (a_data[2] !== 32'h0 || b_data[2] !== 32'h0 || s_data[2] !== 32'h0 ||
        a_busy[2] !== 1'b0 || get_cnt(2) != 1) begin
      errors++;
      $display("FAIL oor_small got %h/%h/%h busy %b cnt %0d exp 0/0/0 0 1",
               a_data[2], b_data[2], s_data[2], a_busy[2], get_cnt(2));
    end
    checks++;
    if (a_data[0] !== 32'hFF || a_busy[0] !== 1'b1 || get_cnt(0) != 2) begin
      errors++;
      $display("FAIL oor_big got %h busy %b cnt %0d exp ff 1 2", a_data[0], a_busy[0], get_cnt(0));
    end
  endtask

  task automatic test_reset_mid();
    tick();
    idle();
    rst_n = 1'b0;
    w1_en = 1'b1; w1_addr = 4'd1; w1_data = 32'h1234;
    bsy_set_en = 1'b1; bsy_set_addr = 4'd3;
    b_addr = 4'd7;
    @(negedge clk);
    checks++;
    if (get_cnt(0) != 2 || b_data[0] !== 32'h77 || b_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_between_edges got cnt %0d data %h busy %b exp 2 77 1",
               get_cnt(0), b_data[0], b_busy[0]);
    end
    tick();
    idle();
    a_addr = 4'd1; b_addr = 4'd7; s_addr = 4'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_data[k] !== 32'h0 || b_data[k] !== 32'h0 || b_busy[k] !== 1'b0 ||
          s_busy[k] !== 1'b0 || get_cnt(k) != 0) begin
        errors++;
        $display("FAIL reset_prio k=%0d got %h/%h busy %b%b cnt %0d exp 0/0 00 0",
                 k, a_data[k], b_data[k], b_busy[k], s_busy[k], get_cnt(k));
      end
    end
  endtask

  task automatic test_random();
    tick();
    for (int n = 0; n < 600; n++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      w1_en        = $urandom_range(0, 1) != 0;
      w2_en        = $urandom_range(0, 1) != 0;
      bsy_set_en   = $urandom_range(0, 2) != 0;
      w1_addr      = 4'($urandom_range(0, 15));
      w2_addr      = ($urandom_range(0, 3) == 0) ? w1_addr : 4'($urandom_range(0, 15));
      bsy_set_addr = ($urandom_range(0, 3) == 0) ? w1_addr : 4'($urandom_range(0, 15));
      w1_data      = $urandom;
      w2_data      = $urandom;
      a_addr       = ($urandom_range(0, 2) == 0) ? w2_addr : 4'($urandom_range(0, 15));
      b_addr       = 4'($urandom_range(0, 15));
      s_addr       = ($urandom_range(0, 2) == 0) ? w1_addr : 4'($urandom_range(0, 15));
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a_data[k] !== exp_data(k, a_addr) || b_data[k] !== exp_data(k, b_addr) ||
            s_data[k] !== exp_data(k, s_addr)) begin
          errors++;
          $display("FAIL rand_data n=%0d k=%0d got %h/%h/%h exp %h/%h/%h", n, k,
                   a_data[k], b_data[k], s_data[k],
                   exp_data(k, a_addr), exp_data(k, b_addr), exp_data(k, s_addr));
        end
        checks++;
        if (a_busy[k] !== exp_busy(k, a_addr) || b_busy[k] !== exp_busy(k, b_addr) ||
            s_busy[k] !== exp_busy(k, s_addr) || get_cnt(k) != exp_cnt(k)) begin
          errors++;
          $display("FAIL rand_busy n=%0d k=%0d got %b%b%b cnt %0d exp %b%b%b cnt %0d", n, k,
                   a_busy[k], b_busy[k], s_busy[k], get_cnt(k),
                   exp_busy(k, a_addr), exp_busy(k, b_addr), exp_busy(k, s_addr), exp_cnt(k));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_dual_write();
    test_bypass();
    test_busy();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
